ctrl_sequencer: RTL and testbench

//  Multi-cycle control FSM for the 16-bit bus processor. Latches the instruction word from DIN.

---
 rtl/proc_pkg.sv | 60 ++++++
 rtl/dec3to8.sv | 26 ++
 rtl/ctrl_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_pkg
//  Description : Shared definitions for the 16-bit bus processor: opcode
//                values, ALU select codes (also used by the ALU), control
//                sequencer state encoding and instruction-word field positions.
//  Revision    : 1.0  initial release
// ============================================================================
package proc_pkg;

    // Instruction word layout: op = IR[15:12], Rx = IR[11:9], Ry = IR[8:6]
    localparam int unsigned c_ir_w      = 16;
    localparam int unsigned c_ir_op_lsb = 12;
    localparam int unsigned c_ir_rx_lsb = 9;
    localparam int unsigned c_ir_ry_lsb = 6;
    localparam int unsigned c_idx_w     = 3;

    // Opcodes; 8..15 are illegal
    localparam logic [3:0] c_op_mv  = 4'd0;
    localparam logic [3:0] c_op_mvi = 4'd1;
    localparam logic [3:0] c_op_add = 4'd2;
    localparam logic [3:0] c_op_sub = 4'd3;
    localparam logic [3:0] c_op_and = 4'd4;
    localparam logic [3:0] c_op_slt = 4'd5;
    localparam logic [3:0] c_op_sll = 4'd6;
    localparam logic [3:0] c_op_srl = 4'd7;

    // ALU select codes; the ALU opcodes are laid out so that alu = op - 2
    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_slt = 3'b011;
    localparam logic [2:0] c_alu_sll = 3'b100;
    localparam logic [2:0] c_alu_srl = 3'b101;

    // Sequencer time steps
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    // True for the six opcodes that use the A/G/ALU path
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= c_op_add) && (op <= c_op_srl);
    endfunction

    // True for any defined opcode
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= c_op_srl;
    endfunction

    // ALU select for an ALU-class opcode
    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        return op[2:0] - 3'd2;
    endfunction

endpackage : proc_pkg
`default_nettype wire

// File: rtl/dec3to8.sv
`default_nettype none
// ============================================================================
//  Module      : dec3to8
//  Description : 3-bit index to 8-bit one-hot decoder with enable. Output is
//                all zeros when disabled, so a disabled decoder never selects
//                a register.
//  Ports       : i_en     - decoder enable
//                i_idx    - register index
//                o_onehot - one-hot select (zero when i_en = 0)
//  Revision    : 1.0  initial release
// ============================================================================
module dec3to8 (
    input  logic       i_en,
    input  logic [2:0] i_idx,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = 8'b0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule : dec3to8
`default_nettype wire

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_sequencer
//  Description : Multi-cycle control FSM for the 16-bit bus processor. Latches
//                the instruction word from DIN in T0 and sequences register
//                file, A, G and bus-source enables over T0..T3. Drives the ALU
//                select. Only the state and IR are registered; all control
//                outputs are decoded combinationally from state and IR.
//  Parameters  : NREGS - number of general registers (one-hot width)
//                OPW   - opcode field width
//  Ports       : Clock  - system clock, rising edge
//                Reset  - synchronous, active-high
//                Run    - start request, sampled in T0 only
//                DIN    - instruction word (T0) / mvi immediate (T1)
//                IRin   - load IR from DIN
//                Rin    - one-hot register write enable
//                Rout   - one-hot register-to-bus enable
//                Ain    - load A from bus
//                Gin    - load G from ALU
//                Gout   - G-to-bus enable
//                DINout - DIN-to-bus enable
//                AluOp  - ALU select
//                Done   - final-cycle pulse of every instruction
//                Illegal- sticky illegal-opcode flag (CTRL_ILLEGAL_EN only)
//  Config      : define CTRL_ILLEGAL_EN to add the Illegal output.
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned NREGS = 8,
    parameter int unsigned OPW   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [15:0]      DIN,
    output logic             IRin,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             Ain,
    output logic             Gin,
    output logic             Gout,
    output logic             DINout,
    output logic [2:0]       AluOp,
    output logic             Done
`ifdef CTRL_ILLEGAL_EN
    ,
    output logic             Illegal
`endif
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_ir_w-1:0]   r_ir;

    // ------------------------------------------------------------------
    // Instruction field decode
    // ------------------------------------------------------------------
    logic [OPW-1:0]      w_op;
    logic [c_idx_w-1:0]  w_rx;
    logic [c_idx_w-1:0]  w_ry;
    logic                w_alu_op;
    logic                w_legal;

    assign w_op     = r_ir[c_ir_op_lsb +: OPW];
    assign w_rx     = r_ir[c_ir_rx_lsb +: c_idx_w];
    assign w_ry     = r_ir[c_ir_ry_lsb +: c_idx_w];
    assign w_alu_op = is_alu_op(w_op);
    assign w_legal  = is_legal_op(w_op);

    // ------------------------------------------------------------------
    // Register select requests feeding the two one-hot decoders
    // ------------------------------------------------------------------
    logic                w_rin_en;
    logic [c_idx_w-1:0]  w_rin_idx;
    logic                w_rout_en;
    logic [c_idx_w-1:0]  w_rout_idx;
    logic [7:0]          w_rin_onehot;
    logic [7:0]          w_rout_onehot;

    // ------------------------------------------------------------------
    // Output decode. Everything is gated by Reset so that an abort in any
    // state issues no write or load in the reset cycle itself.
    // ------------------------------------------------------------------
    always_comb begin
        IRin       = 1'b0;
        w_rin_en   = 1'b0;
        w_rin_idx  = w_rx;
        w_rout_en  = 1'b0;
        w_rout_idx = w_rx;
        Ain        = 1'b0;
        Gin        = 1'b0;
        Gout       = 1'b0;
        DINout     = 1'b0;
        AluOp      = c_alu_add;
        Done       = 1'b0;

        if (!Reset) begin
            case (r_state)
                T0: begin
                    IRin = Run;
                end
                T1: begin
                    if (w_op == c_op_mv) begin
                        // Ry onto the bus, written into Rx; Rx==Ry is a self-copy
                        w_rout_en  = 1'b1;
                        w_rout_idx = w_ry;
                        w_rin_en   = 1'b1;
                        w_rin_idx  = w_rx;
                        Done       = 1'b1;
                    end else if (w_op == c_op_mvi) begin
                        DINout     = 1'b1;
                        w_rin_en   = 1'b1;
                        w_rin_idx  = w_rx;
                        Done       = 1'b1;
                    end else if (w_alu_op) begin
                        w_rout_en  = 1'b1;
                        w_rout_idx = w_rx;
                        Ain        = 1'b1;
                    end else begin
                        // Illegal opcode: finish as a no-op without a write
                        Done       = 1'b1;
                    end
                end
                T2: begin
                    w_rout_en  = 1'b1;
                    w_rout_idx = w_ry;
                    Gin        = 1'b1;
                    AluOp      = alu_sel(w_op);
                end
                T3: begin
                    Gout       = 1'b1;
                    w_rin_en   = 1'b1;
                    w_rin_idx  = w_rx;
                    Done       = 1'b1;
                end
                default: begin
                    IRin = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One-hot register selects
    // ------------------------------------------------------------------
    dec3to8 u_dec_rin (
        .i_en     (w_rin_en),
        .i_idx    (w_rin_idx),
        .o_onehot (w_rin_onehot)
    );

    dec3to8 u_dec_rout (
        .i_en     (w_rout_en),
        .i_idx    (w_rout_idx),
        .o_onehot (w_rout_onehot)
    );

    assign Rin  = NREGS'(w_rin_onehot);
    assign Rout = NREGS'(w_rout_onehot);

    // ------------------------------------------------------------------
    // State and instruction register. Run is only looked at in T0, so a
    // request held through an instruction is first accepted the cycle
    // after Done.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                T0: begin
                    if (Run) begin
                        r_ir    <= DIN;
                        r_state <= T1;
                    end
                end
                T1: begin
                    r_state <= w_alu_op ? T2 : T0;
                end
                T2: begin
                    r_state <= T3;
                end
                T3: begin
                    r_state <= T0;
                end
                default: begin
                    r_state <= T0;
                end
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_EN
    // ------------------------------------------------------------------
    // Sticky illegal flag. The registered part records the event at the
    // end of T1; the combinational term makes the flag visible already in
    // the T1 cycle. It is cleared on the edge where the next Run is taken.
    // ------------------------------------------------------------------
    logic r_illegal;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_illegal <= 1'b0;
        end else if ((r_state == T0) && Run) begin
            r_illegal <= 1'b0;
        end else if ((r_state == T1) && !w_legal) begin
            r_illegal <= 1'b1;
        end
    end

    assign Illegal = !Reset && (r_illegal || ((r_state == T1) && !w_legal));
`else
    // Illegal opcodes complete as a silent no-op; the legality decode is
    // still used by the T1 fall-through above only through w_alu_op.
    logic w_legal_unused;
    assign w_legal_unused = w_legal;
`endif

endmodule : ctrl_sequencer
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_sequencer
//  Description : Self-checking bench for ctrl_sequencer. Directed scenarios
//                queue (stimulus, expected outputs) pairs and compare them as
//                the DUT responds; a random instruction stream checks bus
//                exclusivity, one-hot selects and instruction length.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin;
    logic [7:0]  Rin;
    logic [7:0]  Rout;
    logic        Ain;
    logic        Gin;
    logic        Gout;
    logic        DINout;
    logic [2:0]  AluOp;
    logic        Done;
`ifdef CTRL_ILLEGAL_EN
    logic        Illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_sequencer #(.NREGS(8), .OPW(4)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .Run    (Run),
        .DIN    (DIN),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AluOp  (AluOp),
        .Done   (Done)
`ifdef CTRL_ILLEGAL_EN
        ,
        .Illegal(Illegal)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done}
    logic [24:0] obs;
    assign obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done};

    function automatic logic [24:0] mk(input logic irin, input logic [7:0] rin,
                                       input logic [7:0] rout, input logic ain,
                                       input logic gin, input logic gout,
                                       input logic dinout, input logic [2:0] alu,
                                       input logic done);
        return {irin, rin, rout, ain, gin, gout, dinout, alu, done};
    endfunction

    typedef struct {
        logic        rst;
        logic        run;
        logic [15:0] din;
        logic [24:0] exp;
        logic        ill;
    } stim_t;

    stim_t sq[$];
    int    len_q[$];

    task automatic push(input logic rst, input logic run, input logic [15:0] din,
                        input logic [24:0] exp, input logic ill);
        stim_t s;
        s.rst = rst; s.run = run; s.din = din; s.exp = exp; s.ill = ill;
        sq.push_back(s);
    endtask

    // Every task starts and ends 1 time unit after a rising edge
    task automatic test_reset();
        stim_t s;
        int    c = 0;
        push(1, 1, 16'h2280, '0, 0);
        push(1, 0, 16'h0000, '0, 0);
        push(0, 0, 16'h0000, '0, 0);
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL reset cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
            c++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_mvi();
        stim_t s;
        int    c = 0;
        push(0, 1, 16'h1600, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h00A5, mk(0, 8'h08, 8'h00, 0, 0, 0, 1, 3'd0, 1), 0);
        push(0, 0, 16'h00A5, '0, 0);
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL mvi cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
            c++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_add();
        stim_t s;
        int    c = 0;
        push(0, 1, 16'h2280, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h0000, mk(0, 8'h00, 8'h02, 1, 0, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h0000, mk(0, 8'h00, 8'h04, 0, 1, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h0000, mk(0, 8'h02, 8'h00, 0, 0, 1, 0, 3'd0, 1), 0);
        push(0, 0, 16'h0000, '0, 0);
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL add cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
            c++;
            @(posedge Clock); #1;
        end
    endtask

    // Every ALU opcode with distinct Rx/Ry, AluOp = op - 2 in T2
    task automatic test_alu_ops();
        stim_t       s;
        int          c = 0;
        logic [3:0]  op;
        logic [2:0]  rx, ry, alu;
        logic [7:0]  rxh, ryh;
        for (int k = 2; k <= 7; k++) begin
            op  = 4'(k);
            rx  = 3'(k);
            ry  = 3'(7 - k);
            alu = 3'(k - 2);
            rxh = 8'h01 << k;
            ryh = 8'h01 << (7 - k);
            push(0, 1, {op, rx, ry, 6'h15}, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
            push(0, 0, 16'h0000, mk(0, 8'h00, rxh, 1, 0, 0, 0, 3'd0, 0), 0);
            push(0, 0, 16'h0000, mk(0, 8'h00, ryh, 0, 1, 0, 0, alu, 0), 0);
            push(0, 0, 16'h0000, mk(0, rxh, 8'h00, 0, 0, 1, 0, 3'd0, 1), 0);
        end
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL alu_ops cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
            c++;
            @(posedge Clock); #1;
        end
    endtask

    // srl R7,R0 with Run held high, then mv R5,R5 accepted right after Done
    task automatic test_back_to_back();
        stim_t s;
        int    c = 0;
        push(0, 1, 16'h7E00, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 1, 16'h0B40, mk(0, 8'h00, 8'h80, 1, 0, 0, 0, 3'd0, 0), 0);
        push(0, 1, 16'h0B40, mk(0, 8'h00, 8'h01, 0, 1, 0, 0, 3'b101, 0), 0);
        push(0, 1, 16'h0B40, mk(0, 8'h80, 8'h00, 0, 0, 1, 0, 3'd0, 1), 0);
        push(0, 1, 16'h0B40, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 1, 16'h1600, mk(0, 8'h20, 8'h20, 0, 0, 0, 0, 3'd0, 1), 0);
        push(0, 0, 16'h1600, '0, 0);
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL back_to_back cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
            c++;
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        int    c = 0;
        push(0, 1, 16'hF000, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h0000, mk(0, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 1), 1);
        push(0, 0, 16'h0000, '0, 1);
        push(0, 1, 16'h0B40, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 1);
        push(0, 0, 16'h0000, mk(0, 8'h20, 8'h20, 0, 0, 0, 0, 3'd0, 1), 0);
        push(0, 0, 16'h0000, '0, 0);
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL illegal cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
`ifdef CTRL_ILLEGAL_EN
            n_checks++;
            if (Illegal !== s.ill) begin
                $display("FAIL illegal_flag cyc%0d: got %b expected %b", c, Illegal, s.ill);
                n_fail++;
            end
`endif
            c++;
            @(posedge Clock); #1;
        end
    endtask

    // Reset during T2 of add: nothing issued, then back in T0
    task automatic test_reset_mid();
        stim_t s;
        int    c = 0;
        push(0, 1, 16'h2280, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h0000, mk(0, 8'h00, 8'h02, 1, 0, 0, 0, 3'd0, 0), 0);
        push(1, 1, 16'h0000, '0, 0);
        push(0, 0, 16'h0000, '0, 0);
        push(0, 1, 16'h0B40, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'd0, 0), 0);
        push(0, 0, 16'h0000, mk(0, 8'h20, 8'h20, 0, 0, 0, 0, 3'd0, 1), 0);
        while (sq.size() != 0) begin
            s = sq.pop_front();
            Reset = s.rst; Run = s.run; DIN = s.din;
            @(negedge Clock);
            n_checks++;
            if (obs !== s.exp) begin
                $display("FAIL reset_mid cyc%0d: got %h expected %h", c, obs, s.exp);
                n_fail++;
            end
            c++;
            @(posedge Clock); #1;
        end
    endtask

    // Random stream: expected length queued on issue, compared on Done
    task automatic test_random();
        logic [15:0] instr;
        logic [3:0]  op;
        int          cyc;
        int          exp_len;
        int          bus;
        for (int n = 0; n < 40; n++) begin
            op    = 4'($urandom_range(0, 15));
            instr = {op, 3'($urandom), 3'($urandom), 6'($urandom)};
            len_q.push_back(((op >= 4'd2) && (op <= 4'd7)) ? 4 : 2);
            Reset = 0; Run = 1; DIN = instr;
            @(negedge Clock);
            n_checks++;
            if (IRin !== 1'b1) begin
                $display("FAIL random_accept n%0d: IRin=%b expected 1", n, IRin);
                n_fail++;
            end
            @(posedge Clock); #1;
            cyc = 1;
            while (1) begin
                Run = 1'($urandom); DIN = 16'($urandom);
                @(negedge Clock);
                cyc++;
                bus = $countones(Rout) + int'(Gout) + int'(DINout);
                n_checks++;
                if (bus > 1 || !$onehot0(Rin) || !$onehot0(Rout) || IRin !== 1'b0) begin
                    $display("FAIL random_bus n%0d: Rout=%h Gout=%b DINout=%b Rin=%h IRin=%b",
                             n, Rout, Gout, DINout, Rin, IRin);
                    n_fail++;
                end
                if (Done === 1'b1 || cyc >= 8) break;
                @(posedge Clock); #1;
            end
            exp_len = len_q.pop_front();
            n_checks++;
            if (cyc !== exp_len || Done !== 1'b1) begin
                $display("FAIL random_len n%0d op%0d: %0d cycles, expected %0d", n, op, cyc, exp_len);
                n_fail++;
            end
            @(posedge Clock); #1;
            Run = 0;
            @(negedge Clock);
            n_checks++;
            if (obs !== 25'd0) begin
                $display("FAIL random_idle n%0d: got %h expected 0", n, obs);
                n_fail++;
            end
            @(posedge Clock); #1;
        end
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = 16'h0000;
        @(posedge Clock); #1;
        test_reset();
        test_mvi();
        test_add();
        test_alu_ops();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_ctrl_sequencer
`default_nettype wire
